// File: rtl/seq_det_1010_1011.sv
// Serial detector for the patterns 1010 and 1011 with Mealy and Moore flags
// and a saturating detection counter per pattern.
module seq_det_1010_1011 #(
    parameter int CNT_W   = 8,
    parameter bit OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             mealy_1010,
    output logic             mealy_1011,
    output logic             moore_1010,
    output logic             moore_1011,
    output logic [CNT_W-1:0] cnt_1010,
    output logic [CNT_W-1:0] cnt_1011
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_1,
        S_10,
        S_101,
        S_1010,
        S_1011
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;

    assign mealy_1010 = bit_valid && (state == S_101) && !bit_in;
    assign mealy_1011 = bit_valid && (state == S_101) &&  bit_in;

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (bit_valid) begin
            case (state)
                S_IDLE:  state_nxt = bit_in ? S_1    : S_IDLE;
                S_1:     state_nxt = bit_in ? S_1    : S_10;
                S_10:    state_nxt = bit_in ? S_101  : S_IDLE;
                S_101:   state_nxt = bit_in ? S_1011 : S_1010;
                S_1010:  state_nxt = bit_in ? (OVERLAP ? S_101 : S_1) : S_IDLE;
                S_1011:  state_nxt = bit_in ? S_1 : (OVERLAP ? S_10 : S_IDLE);
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore flags are registered from the next state so they line up with the state register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            moore_1010 <= 1'b0;
            moore_1011 <= 1'b0;
        end else if (bit_valid) begin
            state      <= state_nxt;
            moore_1010 <= (state_nxt == S_1010);
            moore_1011 <= (state_nxt == S_1011);
        end
    end

    // Clear wins over a same-cycle detection; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_1010 <= '0;
            cnt_1011 <= '0;
        end else if (clr_cnt) begin
            cnt_1010 <= '0;
            cnt_1011 <= '0;
        end else begin
            if (mealy_1010 && (cnt_1010 != CNT_MAX)) cnt_1010 <= cnt_1010 + 1'b1;
            if (mealy_1011 && (cnt_1011 != CNT_MAX)) cnt_1011 <= cnt_1011 + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_1010_1011.sv
// Directed bench for seq_det_1010_1011: overlapping, non-overlapping and
// 2-bit-counter instances share one stimulus stream.
module tb_seq_det_1010_1011;

    logic clk = 1'b0;
    logic rst;
    logic bit_valid;
    logic bit_in;
    logic clr_cnt;

    logic       ov_m10, ov_m11, ov_mo10, ov_mo11;
    logic [7:0] ov_c10, ov_c11;
    logic       no_m10, no_m11, no_mo10, no_mo11;
    logic [7:0] no_c10, no_c11;
    logic       w2_m10, w2_m11, w2_mo10, w2_mo11;
    logic [1:0] w2_c10, w2_c11;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_det_1010_1011 #(.CNT_W(8), .OVERLAP(1'b1)) dut_ov (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .mealy_1010(ov_m10), .mealy_1011(ov_m11), .moore_1010(ov_mo10), .moore_1011(ov_mo11),
        .cnt_1010(ov_c10), .cnt_1011(ov_c11)
    );

    seq_det_1010_1011 #(.CNT_W(8), .OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .mealy_1010(no_m10), .mealy_1011(no_m11), .moore_1010(no_mo10), .moore_1011(no_mo11),
        .cnt_1010(no_c10), .cnt_1011(no_c11)
    );

    seq_det_1010_1011 #(.CNT_W(2), .OVERLAP(1'b1)) dut_w2 (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .mealy_1010(w2_m10), .mealy_1011(w2_m11), .moore_1010(w2_mo10), .moore_1011(w2_mo11),
        .cnt_1010(w2_c10), .cnt_1011(w2_c11)
    );

    // Flags are {mealy_1010, mealy_1011, moore_1010, moore_1011}; counts are after the edge.
    typedef struct packed {
        logic       v;
        logic       b;
        logic       c;
        logic [3:0] of;
        logic [7:0] oc10;
        logic [7:0] oc11;
        logic [3:0] nf;
        logic [7:0] nc10;
        logic [7:0] nc11;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic b, input logic c,
                       input logic [3:0] of, input int oc10, input int oc11,
                       input logic [3:0] nf, input int nc10, input int nc11);
        vec_t e;
        e.v = v; e.b = b; e.c = c;
        e.of = of; e.oc10 = 8'(oc10); e.oc11 = 8'(oc11);
        e.nf = nf; e.nc10 = 8'(nc10); e.nc11 = 8'(nc11);
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic c);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        clr_cnt   = c;
    endtask

    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;

        // Patterns 1,0,1,0,1,0,1,0 then back to idle
        add(1,1,0, 4'b0000,0,0, 4'b0000,0,0);
        add(1,0,0, 4'b0000,0,0, 4'b0000,0,0);
        add(1,1,0, 4'b0000,0,0, 4'b0000,0,0);
        add(1,0,0, 4'b1010,1,0, 4'b1010,1,0);
        add(1,1,0, 4'b0000,1,0, 4'b0000,1,0);
        add(1,0,0, 4'b1010,2,0, 4'b0000,1,0);
        add(1,1,0, 4'b0000,2,0, 4'b0000,1,0);
        add(1,0,0, 4'b1010,3,0, 4'b1010,2,0);
        add(1,0,0, 4'b0000,3,0, 4'b0000,2,0);
        // 1,0,1,1,0,1,1 then 0,0 back to idle
        add(1,1,0, 4'b0000,3,0, 4'b0000,2,0);
        add(1,0,0, 4'b0000,3,0, 4'b0000,2,0);
        add(1,1,0, 4'b0000,3,0, 4'b0000,2,0);
        add(1,1,0, 4'b0101,3,1, 4'b0101,2,1);
        add(1,0,0, 4'b0000,3,1, 4'b0000,2,1);
        add(1,1,0, 4'b0000,3,1, 4'b0000,2,1);
        add(1,1,0, 4'b0101,3,2, 4'b0000,2,1);
        add(1,0,0, 4'b0000,3,2, 4'b0000,2,1);
        add(1,0,0, 4'b0000,3,2, 4'b0000,2,1);
        // 1,0,1,0 with three invalid cycles between bits; bit_in toggles while invalid
        add(1,1,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,0,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,1,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,0,0, 4'b0000,3,2, 4'b0000,2,1);
        add(1,0,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,1,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,1,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,0,0, 4'b0000,3,2, 4'b0000,2,1);
        add(1,1,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,0,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,0,0, 4'b0000,3,2, 4'b0000,2,1);
        add(0,1,0, 4'b0000,3,2, 4'b0000,2,1);
        add(1,0,0, 4'b1010,4,2, 4'b1010,3,1);
        add(0,1,0, 4'b0010,4,2, 4'b0010,3,1);
        add(0,0,0, 4'b0010,4,2, 4'b0010,3,1);
        add(0,1,0, 4'b0010,4,2, 4'b0010,3,1);
        add(1,0,0, 4'b0000,4,2, 4'b0000,3,1);
        // Clear coincident with a hit: detection lost, FSM still accepts
        add(1,1,0, 4'b0000,4,2, 4'b0000,3,1);
        add(1,0,0, 4'b0000,4,2, 4'b0000,3,1);
        add(1,1,0, 4'b0000,4,2, 4'b0000,3,1);
        add(1,0,1, 4'b1010,0,0, 4'b1010,0,0);
        add(1,1,0, 4'b0000,0,0, 4'b0000,0,0);
        add(1,0,0, 4'b1010,1,0, 4'b0000,0,0);

        // Reset state, with rst still asserted
        @(posedge clk); #1;
        check("reset ov outputs", {ov_m10, ov_m11, ov_mo10, ov_mo11, ov_c10, ov_c11}, '0);
        check("reset no outputs", {no_m10, no_m11, no_mo10, no_mo11, no_c10, no_c11}, '0);
        check("reset w2 outputs", {w2_m10, w2_m11, w2_mo10, w2_mo11, w2_c10, w2_c11}, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].b, vecs[i].c);
            #1;
            check($sformatf("v%0d ov mealy", i), {ov_m10, ov_m11}, vecs[i].of[3:2]);
            check($sformatf("v%0d no mealy", i), {no_m10, no_m11}, vecs[i].nf[3:2]);
            @(posedge clk); #1;
            check($sformatf("v%0d ov moore", i), {ov_mo10, ov_mo11}, vecs[i].of[1:0]);
            check($sformatf("v%0d no moore", i), {no_mo10, no_mo11}, vecs[i].nf[1:0]);
            check($sformatf("v%0d ov counts", i), {ov_c10, ov_c11}, {vecs[i].oc10, vecs[i].oc11});
            check($sformatf("v%0d no counts", i), {no_c10, no_c11}, {vecs[i].nc10, vecs[i].nc11});
        end

        // Reset mid-sequence: 1,0,1, rst pulse, then 0,1,0 must not complete a match
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) if (i < 3) begin
            drive(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("mid rst ov", {ov_mo10, ov_mo11, ov_c10, ov_c11}, '0);
        check("mid rst no", {no_mo10, no_mo11, no_c10, no_c11}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 1) ? 1'b1 : 1'b0, 1'b0);
            #1;
            check($sformatf("post rst %0d mealy", i), {ov_m10, ov_m11, no_m10, no_m11}, '0);
            @(posedge clk); #1;
            check($sformatf("post rst %0d ov", i), {ov_mo10, ov_mo11, ov_c10, ov_c11}, '0);
            check($sformatf("post rst %0d no", i), {no_mo10, no_mo11, no_c10, no_c11}, '0);
        end

        // Saturation: seven 1,0 pairs from idle give six overlapping 1010 hits
        drive(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        for (int p = 0; p < 7; p++) begin
            drive(1'b1, 1'b1, 1'b0);
            @(posedge clk);
            drive(1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("sat pair %0d mealy", p), 32'(w2_m10), 32'(p >= 1));
            @(posedge clk); #1;
            check($sformatf("sat pair %0d ov cnt", p), 32'(ov_c10), 32'(p));
            check($sformatf("sat pair %0d w2 cnt", p), 32'(w2_c10), 32'((p > 3) ? 3 : p));
        end

        // Clear on the same cycle as a hit while saturated
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        drive(1'b1, 1'b0, 1'b1);
        #1;
        check("clr hit mealy", 32'(w2_m10), 32'd1);
        @(posedge clk); #1;
        check("clr hit w2 cnt", 32'(w2_c10), 32'd0);
        check("clr hit ov cnt", 32'(ov_c10), 32'd0);
        check("clr hit w2 moore", 32'(w2_mo10), 32'd1);
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        drive(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("after clr w2 cnt", 32'(w2_c10), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
